// File: rtl/decode_pkg.sv
// ============================================================================
// Module   : decode_pkg
// Brief    : Shared types and constants for the RV32I decode stage: the
//            fetch/decode and decode/execute bundles, ALU operation enum,
//            base opcodes and the bubble constant.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package decode_pkg;

    localparam int CORE_XLEN  = 32;
    localparam int CORE_NREGS = 32;

    // RV32I base opcodes (instruction bits [6:0])
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    // ALU_ADD must stay at zero so that an all-zero bubble reads as ADD
    typedef enum logic [3:0] {
        ALU_ADD    = 4'd0,
        ALU_SUB    = 4'd1,
        ALU_SLL    = 4'd2,
        ALU_SLT    = 4'd3,
        ALU_SLTU   = 4'd4,
        ALU_XOR    = 4'd5,
        ALU_SRL    = 4'd6,
        ALU_SRA    = 4'd7,
        ALU_OR     = 4'd8,
        ALU_AND    = 4'd9,
        ALU_PASS_B = 4'd10
    } alu_op_e;

    typedef struct packed {
        logic [31:0] instruction_value;
        logic [31:0] pc_value;
    } fe_to_de_s;

    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [31:0] rs1_val;
        logic [31:0] rs2_val;
        logic [31:0] imm;
        logic [2:0]  funct3;
        logic        funct7_b5;
        alu_op_e     alu_op;
        logic        alu_src_imm;
        logic        reg_write;
        logic        mem_read;
        logic        mem_write;
        logic        branch;
        logic        jump;
        logic        illegal;
    } de_to_ex_s;

    // Fetch drives an all-zero word out of reset; decode turns it into a bubble
    localparam fe_to_de_s FE_NOP    = '0;
    localparam de_to_ex_s DE_BUBBLE = '0;

    // ALU operation for OP / OP-IMM from funct3 and the qualified funct7 bit 5
    function automatic alu_op_e alu_decode(input logic [2:0] funct3, input logic b5);
        alu_op_e op;
        case (funct3)
            3'b000:  op = b5 ? ALU_SUB : ALU_ADD;
            3'b001:  op = ALU_SLL;
            3'b010:  op = ALU_SLT;
            3'b011:  op = ALU_SLTU;
            3'b100:  op = ALU_XOR;
            3'b101:  op = b5 ? ALU_SRA : ALU_SRL;
            3'b110:  op = ALU_OR;
            default: op = ALU_AND;
        endcase
        return op;
    endfunction

endpackage

`default_nettype wire

// File: rtl/decode_reg_file.sv
// ============================================================================
// Module   : decode_reg_file
// Brief    : Architectural register file, two combinational read ports and
//            one synchronous write port. x0 reads zero and ignores writes;
//            a same-cycle write is forwarded to the read ports.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module decode_reg_file #(
    parameter int XLEN  = 32,
    parameter int NREGS = 32,
    parameter int AW    = $clog2(NREGS)
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic [AW-1:0]   i_rs1_addr,
    input  logic [AW-1:0]   i_rs2_addr,
    output logic [XLEN-1:0] o_rs1_data,
    output logic [XLEN-1:0] o_rs2_data,
    input  logic            i_wb_en,
    input  logic [AW-1:0]   i_wb_rd,
    input  logic [XLEN-1:0] i_wb_data
);

    logic [XLEN-1:0] r_regs [NREGS];

    // Storage: cleared on reset, written whenever writeback targets a non-zero register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NREGS; i++) begin
                r_regs[i] <= '0;
            end
        end else if (i_wb_en && (i_wb_rd != '0)) begin
            r_regs[i_wb_rd] <= i_wb_data;
        end
    end

    // Read port 1: x0 is zero, a matching writeback this cycle wins over storage
    always_comb begin
        o_rs1_data = '0;
        if (i_rs1_addr != '0) begin
            o_rs1_data = (i_wb_en && (i_wb_rd == i_rs1_addr)) ? i_wb_data : r_regs[i_rs1_addr];
        end
    end

    // Read port 2: same rules as port 1
    always_comb begin
        o_rs2_data = '0;
        if (i_rs2_addr != '0) begin
            o_rs2_data = (i_wb_en && (i_wb_rd == i_rs2_addr)) ? i_wb_data : r_regs[i_rs2_addr];
        end
    end

endmodule

`default_nettype wire

// File: rtl/decode.sv
// ============================================================================
// Module   : decode
// Brief    : RV32I decode stage. Decodes one fetched instruction per cycle,
//            reads the register file and registers the result toward
//            execute, with flush > stall > load priority.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module decode
    import decode_pkg::*;
#(
    parameter int XLEN  = CORE_XLEN,
    parameter int NREGS = CORE_NREGS
) (
    input  logic            clk,
    input  logic            reset_n,
    input  fe_to_de_s       fe_to_de,
    input  logic            stall,
    input  logic            flush,
    input  logic            wb_en,
    input  logic [4:0]      wb_rd,
    input  logic [XLEN-1:0] wb_data,
    output de_to_ex_s       de_to_ex
);

    logic [31:0]     w_instr;
    logic [XLEN-1:0] w_rs1_val;
    logic [XLEN-1:0] w_rs2_val;
    de_to_ex_s       w_dec;
    de_to_ex_s       r_de_to_ex;

    assign w_instr = fe_to_de.instruction_value;

    decode_reg_file #(
        .XLEN  (XLEN),
        .NREGS (NREGS)
    ) u_reg_file (
        .clk        (clk),
        .reset_n    (reset_n),
        .i_rs1_addr (w_instr[19:15]),
        .i_rs2_addr (w_instr[24:20]),
        .o_rs1_data (w_rs1_val),
        .o_rs2_data (w_rs2_val),
        .i_wb_en    (wb_en),
        .i_wb_rd    (wb_rd),
        .i_wb_data  (wb_data)
    );

    // Instruction decode: format-specific immediate and control bits, bubble for the all-zero word
    always_comb begin
        w_dec = DE_BUBBLE;
        if (w_instr != 32'h0) begin
            w_dec.valid     = 1'b1;
            w_dec.pc        = fe_to_de.pc_value;
            w_dec.rs1       = w_instr[19:15];
            w_dec.rs2       = w_instr[24:20];
            w_dec.rd        = w_instr[11:7];
            w_dec.rs1_val   = w_rs1_val;
            w_dec.rs2_val   = w_rs2_val;
            w_dec.funct3    = w_instr[14:12];
            w_dec.funct7_b5 = w_instr[30];
            case (w_instr[6:0])
                OPC_LUI: begin
                    w_dec.imm         = {w_instr[31:12], 12'b0};
                    w_dec.alu_op      = ALU_PASS_B;
                    w_dec.alu_src_imm = 1'b1;
                    w_dec.reg_write   = 1'b1;
                end
                OPC_AUIPC: begin
                    w_dec.imm         = {w_instr[31:12], 12'b0};
                    w_dec.alu_src_imm = 1'b1;
                    w_dec.reg_write   = 1'b1;
                end
                OPC_JAL: begin
                    w_dec.imm         = {{11{w_instr[31]}}, w_instr[31], w_instr[19:12],
                                         w_instr[20], w_instr[30:21], 1'b0};
                    w_dec.alu_src_imm = 1'b1;
                    w_dec.reg_write   = 1'b1;
                    w_dec.jump        = 1'b1;
                end
                OPC_JALR: begin
                    w_dec.imm         = {{20{w_instr[31]}}, w_instr[31:20]};
                    w_dec.alu_src_imm = 1'b1;
                    w_dec.reg_write   = 1'b1;
                    w_dec.jump        = 1'b1;
                end
                OPC_BRANCH: begin
                    w_dec.imm         = {{19{w_instr[31]}}, w_instr[31], w_instr[7],
                                         w_instr[30:25], w_instr[11:8], 1'b0};
                    w_dec.alu_op      = ALU_SUB;
                    w_dec.branch      = 1'b1;
                end
                OPC_LOAD: begin
                    w_dec.imm         = {{20{w_instr[31]}}, w_instr[31:20]};
                    w_dec.alu_src_imm = 1'b1;
                    w_dec.reg_write   = 1'b1;
                    w_dec.mem_read    = 1'b1;
                end
                OPC_STORE: begin
                    w_dec.imm         = {{20{w_instr[31]}}, w_instr[31:25], w_instr[11:7]};
                    w_dec.alu_src_imm = 1'b1;
                    w_dec.mem_write   = 1'b1;
                end
                OPC_OPIMM: begin
                    // Bit 30 is part of the immediate except for SRAI
                    w_dec.imm         = {{20{w_instr[31]}}, w_instr[31:20]};
                    w_dec.alu_op      = alu_decode(w_instr[14:12],
                                                   (w_instr[14:12] == 3'b101) && w_instr[30]);
                    w_dec.alu_src_imm = 1'b1;
                    w_dec.reg_write   = 1'b1;
                end
                OPC_OP: begin
                    w_dec.alu_op      = alu_decode(w_instr[14:12], w_instr[30]);
                    w_dec.reg_write   = 1'b1;
                end
                default: begin
                    w_dec.illegal     = 1'b1;
                end
            endcase
            if (!w_dec.reg_write) begin
                w_dec.rd = '0;
            end
        end
    end

    // Pipeline register toward execute: flush inserts a bubble, stall holds
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_de_to_ex <= DE_BUBBLE;
        end else if (flush) begin
            r_de_to_ex <= DE_BUBBLE;
        end else if (!stall) begin
            r_de_to_ex <= w_dec;
        end
    end

    assign de_to_ex = r_de_to_ex;

endmodule

`default_nettype wire

// File: tb/tb_decode.sv
// ============================================================================
// Module   : tb_decode
// Brief    : Self-checking bench for decode: directed vector table,
//            stall/flush/reset sequences and randomized traffic against a
//            behavioural reference model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_decode;
    import decode_pkg::*;

    logic        clk;
    logic        reset_n;
    fe_to_de_s   fe_to_de;
    logic        stall;
    logic        flush;
    logic        wb_en;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    de_to_ex_s   de_to_ex;

    int n_vec;
    int n_bad;

    logic [31:0] m_regs [32];
    de_to_ex_s   m_exp;

    decode #(
        .XLEN  (32),
        .NREGS (32)
    ) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .fe_to_de (fe_to_de),
        .stall    (stall),
        .flush    (flush),
        .wb_en    (wb_en),
        .wb_rd    (wb_rd),
        .wb_data  (wb_data),
        .de_to_ex (de_to_ex)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    // ---------------- reference model ----------------
    function automatic logic [31:0] ref_read(input logic [4:0] idx);
        if (idx == 5'd0) return 32'h0;
        if (wb_en && wb_rd == idx) return wb_data;
        return m_regs[idx];
    endfunction

    function automatic de_to_ex_s ref_decode(input logic [31:0] ins, input logic [31:0] pc);
        de_to_ex_s d;
        int        sgn;
        alu_op_e   tab [8];
        logic [2:0] f3;
        logic       b5;
        tab = '{ALU_ADD, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR, ALU_SRL, ALU_OR, ALU_AND};
        d = '0;
        if (ins == 32'h0) return d;
        sgn = ins[31] ? -1 : 0;
        f3  = ins[14:12];
        b5  = ins[30];
        d.valid     = 1'b1;
        d.pc        = pc;
        d.rs1       = ins[19:15];
        d.rs2       = ins[24:20];
        d.funct3    = f3;
        d.funct7_b5 = b5;
        d.rs1_val   = ref_read(ins[19:15]);
        d.rs2_val   = ref_read(ins[24:20]);
        case (ins[6:0])
            OPC_LUI:    begin d.imm = ins & 32'hFFFFF000; d.alu_op = ALU_PASS_B;
                              d.alu_src_imm = 1; d.reg_write = 1; end
            OPC_AUIPC:  begin d.imm = ins & 32'hFFFFF000; d.alu_src_imm = 1; d.reg_write = 1; end
            OPC_JAL:    begin d.imm = sgn * 1048576 + int'(ins[19:12]) * 4096 + int'(ins[20]) * 2048
                                      + int'(ins[30:21]) * 2;
                              d.alu_src_imm = 1; d.reg_write = 1; d.jump = 1; end
            OPC_JALR:   begin d.imm = sgn * 4096 + int'(ins[31:20]);
                              d.alu_src_imm = 1; d.reg_write = 1; d.jump = 1; end
            OPC_BRANCH: begin d.imm = sgn * 4096 + int'(ins[7]) * 2048 + int'(ins[30:25]) * 32
                                      + int'(ins[11:8]) * 2;
                              d.alu_op = ALU_SUB; d.branch = 1; end
            OPC_LOAD:   begin d.imm = sgn * 4096 + int'(ins[31:20]);
                              d.alu_src_imm = 1; d.reg_write = 1; d.mem_read = 1; end
            OPC_STORE:  begin d.imm = sgn * 4096 + int'(ins[31:25]) * 32 + int'(ins[11:7]);
                              d.alu_src_imm = 1; d.mem_write = 1; end
            OPC_OPIMM:  begin d.imm = sgn * 4096 + int'(ins[31:20]);
                              d.alu_op = (f3 == 3'd5 && b5) ? ALU_SRA : tab[f3];
                              d.alu_src_imm = 1; d.reg_write = 1; end
            OPC_OP:     begin d.alu_op = (f3 == 3'd0 && b5) ? ALU_SUB :
                                         (f3 == 3'd5 && b5) ? ALU_SRA : tab[f3];
                              d.reg_write = 1; end
            default:    d.illegal = 1;
        endcase
        d.rd = d.reg_write ? ins[11:7] : 5'd0;
        return d;
    endfunction

    // One clock: predict from current inputs, then update model after the edge
    task automatic step();
        de_to_ex_s nxt;
        nxt = ref_decode(fe_to_de.instruction_value, fe_to_de.pc_value);
        @(posedge clk);
        #1;
        if (!reset_n) begin
            m_exp = '0;
            for (int i = 0; i < 32; i++) m_regs[i] = 32'h0;
        end else begin
            if (flush) m_exp = '0;
            else if (!stall) m_exp = nxt;
            if (wb_en && wb_rd != 5'd0) m_regs[wb_rd] = wb_data;
        end
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic chk_s(input string nm, input de_to_ex_s act, input de_to_ex_s exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic [31:0] ins, input logic [31:0] pc);
        fe_to_de.instruction_value = ins;
        fe_to_de.pc_value          = pc;
    endtask

    // ---------------- directed table ----------------
    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
        logic        wen;
        logic [4:0]  wrd;
        logic [31:0] wdat;
        logic        valid;
        logic        illegal;
        logic [4:0]  rd;
        logic [31:0] imm;
        alu_op_e     alu;
        logic [5:0]  ctrl;   // {alu_src_imm, reg_write, mem_read, mem_write, branch, jump}
        logic [31:0] rs1v;
        logic [31:0] rs2v;
    } vec_t;

    vec_t tbl [16];

    initial begin
        logic [31:0] r;
        logic [6:0]  opc;
        logic [6:0]  opcs [9];
        int          k;
        logic [31:0] ins;
        de_to_ex_s   held;

        n_vec = 0;
        n_bad = 0;
        opcs = '{OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR, OPC_BRANCH,
                 OPC_LOAD, OPC_STORE, OPC_OPIMM, OPC_OP};

        tbl[0]  = '{32'h00500093, 32'h100, 1, 5'd1, 32'h20,       1, 0, 5'd1,  32'h5,        ALU_ADD,    6'b110000, 32'h0,        32'h0};
        tbl[1]  = '{32'hFFC0A103, 32'h104, 1, 5'd3, 32'h40,       1, 0, 5'd2,  32'hFFFFFFFC, ALU_ADD,    6'b111000, 32'h20,       32'h0};
        tbl[2]  = '{32'h0021A423, 32'h108, 1, 5'd2, 32'h77,       1, 0, 5'd0,  32'h8,        ALU_ADD,    6'b100100, 32'h40,       32'h77};
        tbl[3]  = '{32'h00528333, 32'h10C, 1, 5'd5, 32'hDEADBEEF, 1, 0, 5'd6,  32'h0,        ALU_ADD,    6'b010000, 32'hDEADBEEF, 32'hDEADBEEF};
        tbl[4]  = '{32'h00000433, 32'h110, 1, 5'd0, 32'h1234,     1, 0, 5'd8,  32'h0,        ALU_ADD,    6'b010000, 32'h0,        32'h0};
        tbl[5]  = '{32'h401284B3, 32'h114, 0, 5'd0, 32'h0,        1, 0, 5'd9,  32'h0,        ALU_SUB,    6'b010000, 32'hDEADBEEF, 32'h20};
        tbl[6]  = '{32'h4030D513, 32'h118, 0, 5'd0, 32'h0,        1, 0, 5'd10, 32'h403,      ALU_SRA,    6'b110000, 32'h20,       32'h40};
        tbl[7]  = '{32'hFFF08593, 32'h11C, 0, 5'd0, 32'h0,        1, 0, 5'd11, 32'hFFFFFFFF, ALU_ADD,    6'b110000, 32'h20,       32'h0};
        tbl[8]  = '{32'hFE308CE3, 32'h120, 0, 5'd0, 32'h0,        1, 0, 5'd0,  32'hFFFFFFF8, ALU_SUB,    6'b000010, 32'h20,       32'h40};
        tbl[9]  = '{32'h001000EF, 32'h124, 0, 5'd0, 32'h0,        1, 0, 5'd1,  32'h800,      ALU_ADD,    6'b110001, 32'h0,        32'h20};
        tbl[10] = '{32'hABCDE637, 32'h128, 0, 5'd0, 32'h0,        1, 0, 5'd12, 32'hABCDE000, ALU_PASS_B, 6'b110000, 32'h0,        32'h0};
        tbl[11] = '{32'h00001697, 32'h12C, 0, 5'd0, 32'h0,        1, 0, 5'd13, 32'h1000,     ALU_ADD,    6'b110000, 32'h0,        32'h0};
        tbl[12] = '{32'h00008067, 32'h130, 0, 5'd0, 32'h0,        1, 0, 5'd0,  32'h0,        ALU_ADD,    6'b110001, 32'h20,       32'h0};
        tbl[13] = '{32'hFFFFFFFF, 32'h134, 0, 5'd0, 32'h0,        1, 1, 5'd0,  32'h0,        ALU_ADD,    6'b000000, 32'h0,        32'h0};
        tbl[14] = '{32'h00000000, 32'h0,   0, 5'd0, 32'h0,        0, 0, 5'd0,  32'h0,        ALU_ADD,    6'b000000, 32'h0,        32'h0};
        tbl[15] = '{32'h00500090, 32'h13C, 0, 5'd0, 32'h0,        1, 1, 5'd0,  32'h0,        ALU_ADD,    6'b000000, 32'h0,        32'hDEADBEEF};

        // ---- reset ----
        reset_n = 1'b0;
        stall   = 1'b0;
        flush   = 1'b0;
        wb_en   = 1'b0;
        wb_rd   = 5'd0;
        wb_data = 32'h0;
        drive(32'h0, 32'h0);
        m_exp = '0;
        for (int i = 0; i < 32; i++) m_regs[i] = 32'h0;
        step();
        step();
        reset_n = 1'b1;
        chk_s("reset_state", de_to_ex, '0);
        step();
        chk_s("bubble_after_reset", de_to_ex, '0);

        // every register reads zero after reset
        for (int i = 0; i < 32; i++) begin
            ins = 32'h00000033 | (32'(i) << 15) | (32'(i) << 20);
            drive(ins, 32'h40 + 32'(i));
            step();
            chk("reg_reset_rs1", de_to_ex.rs1_val, 32'h0);
            chk("reg_reset_rs2", de_to_ex.rs2_val, 32'h0);
        end

        // ---- directed table ----
        for (int v = 0; v < 16; v++) begin
            drive(tbl[v].instr, tbl[v].pc);
            wb_en   = tbl[v].wen;
            wb_rd   = tbl[v].wrd;
            wb_data = tbl[v].wdat;
            step();
            chk("tbl_valid",   32'(de_to_ex.valid),   32'(tbl[v].valid));
            chk("tbl_illegal", 32'(de_to_ex.illegal), 32'(tbl[v].illegal));
            chk("tbl_rd",      32'(de_to_ex.rd),      32'(tbl[v].rd));
            chk("tbl_imm",     de_to_ex.imm,          tbl[v].imm);
            chk("tbl_alu",     32'(de_to_ex.alu_op),  32'(tbl[v].alu));
            chk("tbl_ctrl",    32'({de_to_ex.alu_src_imm, de_to_ex.reg_write, de_to_ex.mem_read,
                                    de_to_ex.mem_write, de_to_ex.branch, de_to_ex.jump}),
                               32'(tbl[v].ctrl));
            chk("tbl_rs1_val", de_to_ex.rs1_val,      tbl[v].rs1v);
            chk("tbl_rs2_val", de_to_ex.rs2_val,      tbl[v].rs2v);
            chk("tbl_pc",      de_to_ex.pc,           tbl[v].pc);
            chk_s("tbl_model", de_to_ex, m_exp);
        end
        wb_en = 1'b0;

        // ---- illegal then stall 3 cycles, then flush over stall ----
        drive(32'hFFFFFFFF, 32'h200);
        step();
        chk("seq_illegal", 32'(de_to_ex.illegal), 32'd1);
        chk("seq_valid",   32'(de_to_ex.valid),   32'd1);
        held = m_exp;
        stall = 1'b1;
        drive(32'h00500093, 32'h204);
        for (int c = 0; c < 3; c++) begin
            wb_en   = (c == 0);
            wb_rd   = 5'd14;
            wb_data = 32'h55;
            step();
            chk_s("stall_hold", de_to_ex, held);
            chk("stall_pc", de_to_ex.pc, 32'h200);
        end
        wb_en = 1'b0;
        flush = 1'b1;
        step();
        chk_s("flush_over_stall", de_to_ex, '0);
        stall = 1'b0;
        flush = 1'b0;
        drive(32'h00E70033, 32'h208);
        step();
        chk("wb_during_stall", de_to_ex.rs1_val, 32'h55);
        chk_s("post_flush_model", de_to_ex, m_exp);

        // ---- async reset while stalled ----
        drive(32'h00500093, 32'h20C);
        step();
        chk("pre_reset_valid", 32'(de_to_ex.valid), 32'd1);
        stall = 1'b1;
        step();
        @(negedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        chk_s("async_reset_clear", de_to_ex, '0);
        m_exp = '0;
        for (int i = 0; i < 32; i++) m_regs[i] = 32'h0;
        step();
        step();
        reset_n = 1'b1;
        stall   = 1'b0;
        drive(32'h00E70033, 32'h210);
        step();
        chk("reset_clears_regs", de_to_ex.rs1_val, 32'h0);
        chk_s("post_reset_model", de_to_ex, m_exp);

        // ---- randomized traffic ----
        for (int n = 0; n < 500; n++) begin
            r = $urandom();
            k = $urandom_range(0, 11);
            if (k < 9) opc = opcs[k];
            else if (k == 9) opc = 7'b0001011;
            else opc = {r[6:2], 2'b10};
            ins = {r[31:25], 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), r[14:12], r[11:7], opc};
            if (k == 11) ins = 32'h0;
            drive(ins, $urandom());
            stall   = ($urandom_range(0, 9) == 0);
            flush   = ($urandom_range(0, 15) == 0);
            wb_en   = 1'($urandom_range(0, 1));
            wb_rd   = 5'($urandom_range(0, 7));
            wb_data = $urandom();
            step();
            chk_s("random_model", de_to_ex, m_exp);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
